// File: rtl/serial_rx.sv
// Serial frame receiver: start, DATA_W bits LSB-first, optional even parity, stop.
// Define RX_PARITY_EN to add the parity bit and parity_err reporting.
module serial_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_RECOVER
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;
  logic              par_ok;
  logic              stop_hi;
  logic              good;

`ifdef RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign par_ok = (par_q == ^shift_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_in) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        shift_d[cnt_q] = rx_in;
        if (cnt_q == LAST) begin
`ifdef RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        par_d   = rx_in;
        state_d = S_STOP;
      end
`endif
      S_STOP:    state_d = rx_in ? S_IDLE : S_RECOVER;
      // A low line here is the tail of a broken frame, not a start bit
      S_RECOVER: if (rx_in) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_DATA) || (state_q == S_STOP);
`ifdef RX_PARITY_EN
    busy    = busy || (state_q == S_PARITY);
`endif
    stop_hi = (state_q == S_STOP) && rx_in;
    good    = stop_hi && par_ok;
    ferr_d  = (state_q == S_STOP) && !rx_in;
    perr_d  = stop_hi && !par_ok;
    ovr_d   = good && valid_q && !rd_ack;
    data_d  = good ? shift_q : data_q;
    valid_d = good ? 1'b1 : (valid_q && !rd_ack);
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx (DATA_W=8); parity cases follow RX_PARITY_EN.
module tb_serial_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_in;
  logic         rd_ack;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] last_good;
  logic [W-1:0] exp_v;

  always #5 clk = ~clk;

  serial_rx #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .rd_ack     (rd_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  task automatic drive(input logic b);
    rx_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop_b,
                            input logic bad_par, input logic ack_stop);
    drive(1'b0);
    for (int i = 0; i < W; i++) drive(d[i]);
`ifdef RX_PARITY_EN
    drive((^d) ^ bad_par);
`endif
    rd_ack = ack_stop;
    drive(stop_b);
    rd_ack = 1'b0;
    if (stop_b && !bad_par) begin
      sb_q.push_back(d);
      last_good = d;
    end
  endtask

  task automatic pop_exp();
    exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
  endtask

  task automatic test_reset();
    rx_in  = 1'b1;
    rd_ack = 1'b0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rx_data, rx_valid, busy, frame_err, parity_err, overrun} !== '0)
      $display("FAIL reset_outs: got %h want 0",
               {rx_data, rx_valid, busy, frame_err, parity_err, overrun});
    else pass_cnt++;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1);
  endtask

  task automatic test_basic();
    drive(1'b0);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else pass_cnt++;
    for (int i = 0; i < W; i++) drive(W'(8'hA5) >> i);
`ifdef RX_PARITY_EN
    drive(1'b0);
`endif
    drive(1'b1);
    sb_q.push_back(8'hA5);
    last_good = 8'hA5;
    total_cnt++;
    if (rx_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", rx_valid);
    else pass_cnt++;
    pop_exp();
    total_cnt++;
    if (rx_data !== exp_v) $display("FAIL basic_data: got %h want %h", rx_data, exp_v);
    else pass_cnt++;
    rd_ack = 1'b1;
    drive(1'b1);
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL ack_clear: got %b want 0", rx_valid);
    else pass_cnt++;
    drive(1'b1);
    rd_ack = 1'b0;
    total_cnt++;
    if ({rx_valid, rx_data} !== {1'b0, last_good})
      $display("FAIL ack_idle: got %b/%h want 0/%h", rx_valid, rx_data, last_good);
    else pass_cnt++;
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (parity_err !== 1'b1) $display("FAIL par_err: got %b want 1", parity_err);
    else pass_cnt++;
    total_cnt++;
    if ({rx_valid, rx_data} !== {1'b0, last_good})
      $display("FAIL par_hold: got %b/%h want 0/%h", rx_valid, rx_data, last_good);
    else pass_cnt++;
    drive(1'b1);
    total_cnt++;
    if (parity_err !== 1'b0) $display("FAIL par_pulse: got %b want 0", parity_err);
    else pass_cnt++;
  endtask
`endif

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL ferr: got %b want 1", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== last_good) $display("FAIL ferr_data: got %h want %h", rx_data, last_good);
    else pass_cnt++;
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL ferr_valid: got %b want 0", rx_valid);
    else pass_cnt++;
    drive(1'b0);
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL ferr_pulse: got %b want 0", frame_err);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) drive(1'b0);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL recover_busy: got %b want 0", busy);
    else pass_cnt++;
    drive(1'b1);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    pop_exp();
    total_cnt++;
    if ({rx_valid, rx_data} !== {1'b1, exp_v})
      $display("FAIL recover_rx: got %b/%h want 1/%h", rx_valid, rx_data, exp_v);
    else pass_cnt++;
    rd_ack = 1'b1;
    drive(1'b1);
    rd_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    pop_exp();
    total_cnt++;
    if (rx_data !== exp_v) $display("FAIL b2b_first: got %h want %h", rx_data, exp_v);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL b2b_ovr0: got %b want 0", overrun);
    else pass_cnt++;
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    pop_exp();
    total_cnt++;
    if ({rx_valid, rx_data} !== {1'b1, exp_v})
      $display("FAIL b2b_second: got %b/%h want 1/%h", rx_valid, rx_data, exp_v);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL b2b_ovr: got %b want 1", overrun);
    else pass_cnt++;
    drive(1'b1);
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL b2b_ovr_pulse: got %b want 0", overrun);
    else pass_cnt++;
    rd_ack = 1'b1;
    drive(1'b1);
    rd_ack = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    pop_exp();
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    pop_exp();
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL b2b_ack_ovr: got %b want 0", overrun);
    else pass_cnt++;
    total_cnt++;
    if ({rx_valid, rx_data} !== {1'b1, exp_v})
      $display("FAIL b2b_ack_rx: got %b/%h want 1/%h", rx_valid, rx_data, exp_v);
    else pass_cnt++;
    rd_ack = 1'b1;
    drive(1'b1);
    rd_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rx_data, rx_valid, busy, frame_err, parity_err, overrun} !== '0)
      $display("FAIL mid_reset: got %h want 0",
               {rx_data, rx_valid, busy, frame_err, parity_err, overrun});
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1);
    total_cnt++;
    if ({busy, frame_err, parity_err, overrun} !== 4'b0)
      $display("FAIL mid_quiet: got %b want 0000",
               {busy, frame_err, parity_err, overrun});
    else pass_cnt++;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    pop_exp();
    total_cnt++;
    if ({rx_valid, rx_data} !== {1'b1, exp_v})
      $display("FAIL mid_rx: got %b/%h want 1/%h", rx_valid, rx_data, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    last_good = '0;
    test_reset();
    test_basic();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d want 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, number of message bits per frame.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, one line bit per cycle.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rx_in  input  1  serial line, idle high, same clock domain as the transmitter.
REQ-005 SHALL have port: rd_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-006 SHALL have port: rx_data  output  DATA_W  last good received message, LSB = first data bit on the line.
REQ-007 SHALL have port: rx_valid  output  1  level; high while rx_data holds an unacknowledged message.
REQ-008 SHALL have port: busy  output  1  high in DATA, PARITY and STOP states.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port: parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 without RX_PARITY_EN.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse when a good frame overwrites unacknowledged data.

Function
REQ-012 SHALL sample rx_in on every rising clk edge; frame = start bit (0), DATA_W data bits LSB-first, optional parity bit, one stop cycle (1).
REQ-013 SHALL implement states IDLE, DATA, PARITY, STOP, RECOVER.
REQ-014 IDLE: rx_in=0 -> DATA with bit counter cleared; rx_in=1 -> stay.
REQ-015 DATA: shift rx_in into bit position counter, increment counter; after bit DATA_W-1 -> PARITY (parity enabled) or STOP.
REQ-016 PARITY: capture rx_in as parity bit -> STOP; expected value = even parity (XOR of all DATA_W data bits).
REQ-017 STOP: rx_in=1 -> frame good, next state IDLE; rx_in=0 -> frame_err pulse, data discarded, next state RECOVER.
REQ-018 RECOVER: stay until rx_in=1, then -> IDLE; a low line after a framing error is never taken as a start bit.
REQ-019 Good frame with parity match: on the edge sampling the stop bit, rx_data loads and rx_valid sets (visible next cycle).
REQ-020 Good stop bit with parity mismatch: parity_err pulse, rx_data and rx_valid unchanged.
REQ-021 rd_ack=1 while rx_valid=1 clears rx_valid next cycle; rd_ack while rx_valid=0 has no effect.
REQ-022 Good frame completing while rx_valid=1 and rd_ack=0: rx_data overwritten, rx_valid stays 1, overrun pulse.
REQ-023 Good frame completing on the same edge as rd_ack: new data loads, rx_valid stays 1, no overrun.
REQ-024 Back-to-back frames with exactly one idle-high cycle between them (the stop cycle) SHALL be received without loss.
REQ-025 Bit counter SHALL be $clog2(DATA_W) bits wide, minimum 1, never wrapping within a frame.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, parity_err 0, overrun 0.
REQ-027 Reset mid-frame SHALL abandon the partial frame with no pulses; after release, reception restarts at the next 0 on rx_in.

Configuration
REQ-028 SHALL use macro RX_PARITY_EN: defined -> PARITY state present, frame is DATA_W+2 bits plus stop; undefined -> PARITY state absent, DATA goes directly to STOP, parity_err constant 0.

Verification (DATA_W=8)
REQ-029 Parity off: rx_in 0,1,0,1,0,0,1,0,1,1 -> rx_data=0xA5, rx_valid=1 on the cycle after the stop bit.
REQ-030 Parity on: 0, 0xA5 LSB-first, parity 0, stop 1 -> rx_data=0xA5, valid; same with parity 1 -> parity_err pulse, rx_valid stays 0.
REQ-031 0x3C with stop=0 -> frame_err pulse, rx_data unchanged; rx_in held 0 for 5 cycles -> no new frame until rx_in=1 then 0.
REQ-032 Frames 0x11 then 0x22, one idle cycle between, no rd_ack -> rx_data=0x22, overrun pulse once; repeat with rd_ack on completion edge -> no overrun.
REQ-033 rst_n pulsed after 4 data bits of 0xFF -> all outputs 0; following frame 0x5A received correctly.
